fifo_read_ctrl: RTL and testbench

Burst read engine for the read port of the team's synchronous FIFO/SRAM buffer. It consumes the words the write side has stored in that buffer. A start pulse loads a burst length. The block then issues read strobes whenever the FIFO is non-empty, absorbs the FIFO's one-cycle read latency in a 2-entry output buffer, and presents the words downstream on a valid/ready handshake. It pulses done once the last word of the burst has been accepted downstream.

---
 rtl/fifo_read_ctrl_if.sv | 29 ++
 rtl/fifo_read_ctrl.sv | 125 ++++++++++++
 tb/tb_fifo_read_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_read_ctrl_if.sv
// Signal bundle between the burst read engine, the FIFO read port and the downstream sink.
// The master modport is the engine side; slave is the FIFO/sink environment.
interface fifo_read_ctrl_if #(
    parameter int unsigned BITS    = 12,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned STALL_W = 16
);
    logic               start;
    logic [LEN_W-1:0]   burst_len;
    logic               fifo_empty;
    logic               fifo_rd;
    logic [BITS-1:0]    fifo_rdata;
    logic [BITS-1:0]    out_data;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               done;
    logic [STALL_W-1:0] stall_cnt;

    modport master (
        input  start, burst_len, fifo_empty, fifo_rdata, out_ready,
        output fifo_rd, out_data, out_valid, busy, done, stall_cnt
    );

    modport slave (
        output start, burst_len, fifo_empty, fifo_rdata, out_ready,
        input  fifo_rd, out_data, out_valid, busy, done, stall_cnt
    );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Burst read engine: issues FIFO reads, hides the one-cycle read latency in a
// 2-entry skid buffer and hands words downstream on valid/ready.
module fifo_read_ctrl #(
    parameter int unsigned BITS    = 12,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned STALL_W = 16
) (
    input logic            clk,
    input logic            rst_n,
    fifo_read_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    state_t             r_state, w_state_nxt;
    logic [LEN_W-1:0]   r_remaining, w_remaining_nxt;
    logic [STALL_W-1:0] r_stall, w_stall_nxt;
    logic [1:0]         r_occ, w_occ_nxt, w_occ_kept;
    logic               r_inflight;
    logic [BITS-1:0]    r_buf0, r_buf1, w_buf0_nxt, w_buf1_nxt;
    logic               r_valid, r_busy, r_done, w_done_nxt;
    logic               w_pop, w_room, w_rd;

    // Next-state, buffer and counter logic
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_stall_nxt     = r_stall;
        w_buf0_nxt      = r_buf0;
        w_buf1_nxt      = r_buf1;

        w_pop      = r_valid && bus.out_ready;
        w_occ_kept = r_occ - 2'(w_pop);
        // A read is only allowed if the word it returns is guaranteed a slot
        w_room     = (3'(w_occ_kept) + 3'(r_inflight)) < 3'd2;
        w_rd       = (r_state == S_RUN) && (r_remaining != '0) && !bus.fifo_empty && w_room;
        w_occ_nxt  = w_occ_kept + 2'(r_inflight);

        if (w_pop) begin
            w_buf0_nxt = r_buf1;
        end
        if (r_inflight) begin
            if (w_occ_kept == 2'd0) begin
                w_buf0_nxt = bus.fifo_rdata;
            end else begin
                w_buf1_nxt = bus.fifo_rdata;
            end
        end

        if (w_rd) begin
            w_remaining_nxt = r_remaining - LEN_W'(1);
        end
        if ((r_state == S_RUN) && (r_remaining != '0) && bus.fifo_empty && (r_stall != STALL_MAX)) begin
            w_stall_nxt = r_stall + STALL_W'(1);
        end

        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.burst_len != '0) begin
                        w_remaining_nxt = bus.burst_len;
                        w_stall_nxt     = '0;
                        w_state_nxt     = S_RUN;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_RUN: begin
                if (w_remaining_nxt == '0) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((r_occ == 2'd0) && !r_inflight) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // done is registered so it lands on the final DRAIN cycle
        w_done_nxt = (w_state_nxt == S_DRAIN) && (w_occ_nxt == 2'd0) && !w_rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_stall     <= '0;
            r_occ       <= 2'd0;
            r_inflight  <= 1'b0;
            r_buf0      <= '0;
            r_buf1      <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_stall     <= w_stall_nxt;
            r_occ       <= w_occ_nxt;
            r_inflight  <= w_rd;
            r_buf0      <= w_buf0_nxt;
            r_buf1      <= w_buf1_nxt;
            r_valid     <= (w_occ_nxt != 2'd0);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= w_done_nxt;
        end
    end

    assign bus.fifo_rd   = w_rd;
    assign bus.out_data  = r_buf0;
    assign bus.out_valid = r_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.stall_cnt = r_stall;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: FIFO model with one-cycle read latency, burst vector
// table, output scoreboard, plus a mid-burst reset sequence.
module tb_fifo_read_ctrl;
    localparam int unsigned BITS    = 12;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned STALL_W = 16;

    typedef logic [BITS-1:0] word_t;
    typedef struct {
        int len;
        int preload;
        int hold;
        int gap;
        int rmode;
        bit poke;
        int exp_rd;
        int exp_stall;
        int exp_left;
        bit timing;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_read_ctrl_if #(.BITS(BITS), .LEN_W(LEN_W), .STALL_W(STALL_W)) bus ();

    fifo_read_ctrl #(.BITS(BITS), .LEN_W(LEN_W), .STALL_W(STALL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    word_t mem_q[$];
    word_t held_q[$];
    word_t exp_q[$];
    word_t rd_word;
    bit    rd_pend;
    word_t bp_head;
    bit    bp_done;
    int    gap, gap_cnt, rmode, bp_left;
    int    rd_cnt, pop_cnt, done_cnt, blk_rd, max_occ;
    int    first_rd, last_rd, first_valid, first_pop, last_pop, done_cyc, start_cyc;
    logic [STALL_W-1:0] stall_at_done;

    vec_t vecs[6];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        rd_cnt = 0; pop_cnt = 0; done_cnt = 0; blk_rd = 0; max_occ = 0;
        first_rd = -1; last_rd = -1; first_valid = -1; first_pop = -1; last_pop = -1;
        done_cyc = -1; bp_done = 1'b0; bp_left = 0; gap_cnt = 0;
        stall_at_done = '0;
    endtask

    // One clock cycle: drive FIFO/sink at the falling edge, then sample and score
    task automatic cycle();
        bit blocked;
        @(negedge clk);
        if (rd_pend) begin
            bus.fifo_rdata = rd_word;
            rd_pend = 1'b0;
        end
        if (held_q.size() != 0 && gap_cnt >= gap) begin
            while (held_q.size() != 0) mem_q.push_back(held_q.pop_front());
        end
        bus.fifo_empty = (mem_q.size() == 0);
        if (bus.fifo_empty && held_q.size() != 0 && bus.busy) gap_cnt++;
        blocked = 1'b0;
        case (rmode)
            0: bus.out_ready = 1'b1;
            1: begin
                if (bp_left > 0) begin
                    bus.out_ready = 1'b0; bp_left--; blocked = 1'b1;
                end else if (bus.out_valid && !bp_done) begin
                    bp_done = 1'b1; bp_left = 4; bus.out_ready = 1'b0; blocked = 1'b1;
                    bp_head = exp_q[0];
                end else begin
                    bus.out_ready = 1'b1;
                end
            end
            2: bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
        endcase
        #1;
        if (bus.out_valid && first_valid < 0) first_valid = cyc;
        if (blocked && bus.out_valid) check("bp_hold", bus.out_data, bp_head);
        if (bus.fifo_empty) check("rd_on_empty", bus.fifo_rd, 0);
        if (bus.out_valid && bus.out_ready) begin
            pop_cnt++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            if (exp_q.size() == 0) check("extra_word", 1, 0);
            else check("data", bus.out_data, exp_q.pop_front());
        end
        if (rd_cnt - pop_cnt > max_occ) max_occ = rd_cnt - pop_cnt;
        if (bus.fifo_rd) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            if (blocked) blk_rd++;
            if (mem_q.size() != 0) rd_word = mem_q.pop_front();
            rd_pend = 1'b1;
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
            stall_at_done = bus.stall_cnt;
        end
        cyc++;
    endtask

    task automatic run_vec(input vec_t v, input bit rnd);
        word_t w;
        clear_stats();
        gap = v.gap;
        rmode = v.rmode;
        mem_q.delete(); held_q.delete(); exp_q.delete();
        for (int i = 0; i < v.preload + v.hold; i++) begin
            w = rnd ? word_t'($urandom) : word_t'(i + 1);
            if (i < v.preload) mem_q.push_back(w);
            else held_q.push_back(w);
            if (i < v.len) exp_q.push_back(w);
        end
        start_cyc = cyc - 1;
        bus.burst_len = LEN_W'(v.len);
        bus.start = 1'b1;
        for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
            cycle();
            if (i == 0) bus.start = 1'b0;
            if (v.poke && i == 1) begin
                bus.start = 1'b1;
                bus.burst_len = LEN_W'(200);
            end
            if (v.poke && i == 2) bus.start = 1'b0;
        end
        bus.start = 1'b0;
        if (done_cnt == 0) check("timeout", 0, 1);
        repeat (4) cycle();
        check("rd_count", rd_cnt, v.exp_rd);
        check("done_count", done_cnt, 1);
        check("words_left", exp_q.size(), 0);
        check("fifo_left", mem_q.size() + held_q.size(), v.exp_left);
        check("busy_after", bus.busy, 0);
        if (v.exp_stall >= 0) check("stall", stall_at_done, v.exp_stall);
        if (v.len == 0) check("zero_done_lat", done_cyc, start_cyc + 1);
        if (v.timing) begin
            check("valid_lat", first_valid - first_rd, 2);
            check("rd_span", last_rd - first_rd, v.len - 1);
            check("pop_span", last_pop - first_pop, v.len - 1);
            check("done_lat", done_cyc - last_pop, 1);
        end
        if (v.rmode == 1) check("bp_rd_blocked", blk_rd <= 2, 1);
        if (rnd) check("max_occ", max_occ <= 2, 1);
    endtask

    initial begin
        // len preload hold gap rmode poke exp_rd exp_stall exp_left timing
        vecs[0] = '{8,   8,   0, 0, 0, 1'b0, 8,   0,  0, 1'b1};
        vecs[1] = '{4,   4,   0, 0, 1, 1'b0, 4,   0,  0, 1'b0};
        vecs[2] = '{4,   2,   2, 6, 0, 1'b0, 4,   6,  0, 1'b0};
        vecs[3] = '{0,   0,   0, 0, 0, 1'b0, 0,   -1, 0, 1'b0};
        vecs[4] = '{4,   6,   0, 0, 0, 1'b1, 4,   0,  2, 1'b0};
        vecs[5] = '{255, 255, 0, 0, 2, 1'b0, 255, 0,  0, 1'b0};

        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.burst_len = '0;
        bus.fifo_empty = 1'b1;
        bus.fifo_rdata = '0;
        bus.out_ready = 1'b0;
        rd_pend = 1'b0;
        rd_word = '0;
        bp_head = '0;
        gap = 0;
        rmode = 0;
        clear_stats();

        repeat (2) @(negedge clk);
        #1;
        check("rst_fifo_rd", bus.fifo_rd, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_stall", bus.stall_cnt, 0);
        rst_n = 1'b1;
        repeat (2) cycle();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i == 5);

        // Reset while two words sit in the output buffer
        clear_stats();
        gap = 0;
        rmode = 3;
        mem_q.delete(); held_q.delete(); exp_q.delete();
        for (int i = 0; i < 8; i++) mem_q.push_back(word_t'(i + 1));
        bus.burst_len = LEN_W'(8);
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        repeat (4) cycle();
        check("pre_rst_valid", bus.out_valid, 1);
        check("pre_rst_occ", rd_cnt - pop_cnt, 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_fifo_rd", bus.fifo_rd, 0);
        check("mid_rst_done", bus.done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd_pend = 1'b0;
        mem_q.delete();
        done_cnt = 0;
        rmode = 0;
        repeat (3) cycle();
        check("no_done_after_rst", done_cnt, 0);
        run_vec('{3, 3, 0, 0, 0, 1'b0, 3, 0, 0, 1'b1}, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
